// File: rtl/ex_stage_pipe.sv
// Execute stage with a valid/ready handshake on both sides, branch target and forwarding outputs.
// Optional multi-cycle multiplier is enabled by defining EX_MUL_EN.
module ex_stage_pipe #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned REG_AW     = 3,
   parameter int unsigned MUL_CYCLES = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [2:0]        ALUOP,
   input  logic [DATA_W-1:0] OPERAND1,
   input  logic [DATA_W-1:0] OPERAND2,
   input  logic [DATA_W-1:0] PC,
   input  logic [DATA_W-1:0] PC_OFFSET,
   input  logic [DATA_W-1:0] MEM_OFFSET,
   input  logic [REG_AW-1:0] DR,
   input  logic              BRANCH_IN,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [DATA_W-1:0] RESULT,
   output logic [DATA_W-1:0] MEMDATA,
   output logic [2:0]        OP_to_MEM,
   output logic [REG_AW-1:0] DR_to_MEM,
   output logic [2:0]        CC,
   output logic              BRANCH_OUT,
   output logic [DATA_W-1:0] BRANCH_ADDR,
   output logic [DATA_W-1:0] EX_result_forward,
   output logic              FWD_VALID,
   output logic [REG_AW-1:0] DR_EX_RETURN
);
   localparam int unsigned SH_W = $clog2(DATA_W);

   localparam logic [2:0] OP_BR  = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_MEM = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] memdata_q, memdata_d;
   logic [2:0]        op_q, op_d;
   logic [REG_AW-1:0] dr_q, dr_d;
   logic [2:0]        cc_q, cc_d;

   logic              accept, out_free, idle, is_mul, mul_done;
   logic [DATA_W-1:0] alu_res, br_sum, mul_res, mul_opb;
   logic [REG_AW-1:0] mul_dr;

   function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] v);
      if (v == '0)          return 3'b010;
      else if (v[DATA_W-1]) return 3'b100;
      else                  return 3'b001;
   endfunction

   assign out_free = !out_valid_q | OUT_READY;
   assign IN_READY = idle & out_free;
   assign accept   = IN_VALID & IN_READY;

   assign br_sum = PC + {PC_OFFSET[DATA_W-2:0], 1'b0};

   // Single-cycle ALU; opcode 111 yields zero here (the multiplier, if present, lives below)
   always_comb begin
      alu_res = '0;
      case (ALUOP)
         OP_BR:   alu_res = br_sum;
         OP_ADD:  alu_res = OPERAND1 + OPERAND2;
         OP_MEM:  alu_res = OPERAND1 + {MEM_OFFSET[DATA_W-2:0], 1'b0};
         OP_SUB:  alu_res = OPERAND1 - OPERAND2;
         OP_AND:  alu_res = OPERAND1 & OPERAND2;
         OP_XOR:  alu_res = OPERAND1 ^ OPERAND2;
         OP_SHL:  alu_res = OPERAND1 << OPERAND2[SH_W-1:0];
         default: alu_res = '0;
      endcase
   end

`ifdef EX_MUL_EN
   localparam int unsigned CNT_W = $clog2(MUL_CYCLES);

   typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [REG_AW-1:0] mul_dr_q, mul_dr_d;

   assign is_mul = (ALUOP == OP_MUL);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         mul_dr_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         mul_dr_q <= mul_dr_d;
      end
   end

   // A finished multiply parks in MUL_BUSY until the output register can take it
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (accept && is_mul) state_d = S_MUL_BUSY;
         S_MUL_BUSY: if (cnt_q == '0 && out_free) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d    = cnt_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      mul_dr_d = mul_dr_q;
      if (accept && is_mul) begin
         cnt_d    = CNT_W'(MUL_CYCLES - 1);
         mul_a_d  = OPERAND1;
         mul_b_d  = OPERAND2;
         mul_dr_d = DR;
      end else if (state_q == S_MUL_BUSY && cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   assign idle     = (state_q == S_IDLE);
   assign mul_done = (state_q == S_MUL_BUSY) && (cnt_q == '0) && out_free;
   assign mul_res  = mul_a_q * mul_b_q;
   assign mul_opb  = mul_b_q;
   assign mul_dr   = mul_dr_q;
`else
   assign is_mul   = 1'b0;
   assign idle     = 1'b1;
   assign mul_done = 1'b0;
   assign mul_res  = '0;
   assign mul_opb  = '0;
   assign mul_dr   = '0;
`endif

   // Output register: load on completion, otherwise drain when MEM takes the result
   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      memdata_d   = memdata_q;
      op_d        = op_q;
      dr_d        = dr_q;
      cc_d        = cc_q;
      if (mul_done) begin
         out_valid_d = 1'b1;
         result_d    = mul_res;
         memdata_d   = mul_opb;
         op_d        = OP_MUL;
         dr_d        = mul_dr;
         cc_d        = cc_of(mul_res);
      end else if (accept && !is_mul) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         memdata_d   = OPERAND2;
         op_d        = ALUOP;
         dr_d        = DR;
         if (ALUOP != OP_BR && ALUOP != OP_MEM) cc_d = cc_of(alu_res);
      end else if (OUT_READY) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         memdata_q   <= '0;
         op_q        <= '0;
         dr_q        <= '0;
         cc_q        <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         memdata_q   <= memdata_d;
         op_q        <= op_d;
         dr_q        <= dr_d;
         cc_q        <= cc_d;
      end
   end

   assign OUT_VALID         = out_valid_q;
   assign RESULT            = result_q;
   assign MEMDATA           = memdata_q;
   assign OP_to_MEM         = op_q;
   assign DR_to_MEM         = dr_q;
   assign CC                = cc_q;
   assign BRANCH_ADDR       = br_sum;
   assign BRANCH_OUT        = accept & BRANCH_IN & (ALUOP == OP_BR);
   assign EX_result_forward = alu_res;
   assign FWD_VALID         = accept & (ALUOP != OP_BR) & (ALUOP != OP_MEM) & (ALUOP != OP_MUL);
   assign DR_EX_RETURN      = DR;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed testbench for ex_stage_pipe (DATA_W=16); the multiply scenario follows EX_MUL_EN.
module tb_ex_stage_pipe;
   logic        CLK = 1'b0;
   logic        RESET;
   logic        IN_VALID;
   logic        IN_READY;
   logic [2:0]  ALUOP;
   logic [15:0] OPERAND1, OPERAND2, PC, PC_OFFSET, MEM_OFFSET;
   logic [2:0]  DR;
   logic        BRANCH_IN;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [15:0] RESULT, MEMDATA, BRANCH_ADDR, EX_result_forward;
   logic [2:0]  OP_to_MEM, DR_to_MEM, CC, DR_EX_RETURN;
   logic        BRANCH_OUT, FWD_VALID;

   int n_cmp = 0;
   int n_err = 0;

   ex_stage_pipe #(.DATA_W(16), .REG_AW(3), .MUL_CYCLES(4)) dut (
      .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .ALUOP(ALUOP), .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .PC(PC),
      .PC_OFFSET(PC_OFFSET), .MEM_OFFSET(MEM_OFFSET), .DR(DR), .BRANCH_IN(BRANCH_IN),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RESULT(RESULT), .MEMDATA(MEMDATA),
      .OP_to_MEM(OP_to_MEM), .DR_to_MEM(DR_to_MEM), .CC(CC), .BRANCH_OUT(BRANCH_OUT),
      .BRANCH_ADDR(BRANCH_ADDR), .EX_result_forward(EX_result_forward),
      .FWD_VALID(FWD_VALID), .DR_EX_RETURN(DR_EX_RETURN)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] d);
      IN_VALID = 1'b1;
      ALUOP    = op;
      OPERAND1 = a;
      OPERAND2 = b;
      DR       = d;
   endtask

   task automatic test_reset();
      RESET = 1'b1; OUT_READY = 1'b1; BRANCH_IN = 1'b0;
      PC = '0; PC_OFFSET = '0; MEM_OFFSET = '0;
      drive(3'b001, 16'h0001, 16'h0001, 3'd1);
      tick();
      tick();
      n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %h want 0", OUT_VALID); end
      n_cmp++; if (RESULT !== 16'h0000) begin n_err++; $display("FAIL reset_result got %h want 0000", RESULT); end
      n_cmp++; if (CC !== 3'b000) begin n_err++; $display("FAIL reset_cc got %b want 000", CC); end
      n_cmp++; if (MEMDATA !== 16'h0000 || OP_to_MEM !== 3'b000 || DR_to_MEM !== 3'd0) begin
         n_err++; $display("FAIL reset_regs got md=%h op=%b dr=%h want 0", MEMDATA, OP_to_MEM, DR_to_MEM); end
      RESET = 1'b0; IN_VALID = 1'b0;
      #1;
      n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %h want 1", IN_READY); end
   endtask

   task automatic test_add();
      drive(3'b001, 16'h7FFF, 16'h0001, 3'd3);
      #1;
      n_cmp++; if (FWD_VALID !== 1'b1) begin n_err++; $display("FAIL add_fwd_valid got %h want 1", FWD_VALID); end
      n_cmp++; if (EX_result_forward !== 16'h8000) begin n_err++; $display("FAIL add_fwd got %h want 8000", EX_result_forward); end
      n_cmp++; if (BRANCH_OUT !== 1'b0) begin n_err++; $display("FAIL add_branch_out got %h want 0", BRANCH_OUT); end
      n_cmp++; if (DR_EX_RETURN !== 3'd3) begin n_err++; $display("FAIL add_dr_ex got %h want 3", DR_EX_RETURN); end
      tick();
      IN_VALID = 1'b0;
      n_cmp++; if (RESULT !== 16'h8000) begin n_err++; $display("FAIL add_result got %h want 8000", RESULT); end
      n_cmp++; if (CC !== 3'b100) begin n_err++; $display("FAIL add_cc got %b want 100", CC); end
      n_cmp++; if (OUT_VALID !== 1'b1) begin n_err++; $display("FAIL add_out_valid got %h want 1", OUT_VALID); end
      n_cmp++; if (OP_to_MEM !== 3'b001 || DR_to_MEM !== 3'd3 || MEMDATA !== 16'h0001) begin
         n_err++; $display("FAIL add_regs got op=%b dr=%h md=%h want 001/3/0001", OP_to_MEM, DR_to_MEM, MEMDATA); end
   endtask

   task automatic test_back_to_back();
      drive(3'b011, 16'h0005, 16'h0005, 3'd2);
      #1;
      n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL b2b_ready0 got %h want 1", IN_READY); end
      tick();
      n_cmp++; if (RESULT !== 16'h0000 || CC !== 3'b010) begin
         n_err++; $display("FAIL b2b_sub got %h/%b want 0000/010", RESULT, CC); end
      drive(3'b110, 16'h0001, 16'h000F, 3'd4);
      #1;
      n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL b2b_ready1 got %h want 1", IN_READY); end
      tick();
      IN_VALID = 1'b0;
      n_cmp++; if (RESULT !== 16'h8000 || CC !== 3'b100 || OUT_VALID !== 1'b1) begin
         n_err++; $display("FAIL b2b_shl got %h/%b/%h want 8000/100/1", RESULT, CC, OUT_VALID); end
      tick();
      n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %h want 0", OUT_VALID); end
   endtask

   task automatic test_branch();
      PC = 16'h0100; PC_OFFSET = 16'h0010; BRANCH_IN = 1'b1;
      drive(3'b000, 16'h1111, 16'h2222, 3'd0);
      #1;
      n_cmp++; if (BRANCH_ADDR !== 16'h0120) begin n_err++; $display("FAIL br_addr got %h want 0120", BRANCH_ADDR); end
      n_cmp++; if (BRANCH_OUT !== 1'b1) begin n_err++; $display("FAIL br_out got %h want 1", BRANCH_OUT); end
      n_cmp++; if (FWD_VALID !== 1'b0) begin n_err++; $display("FAIL br_fwd_valid got %h want 0", FWD_VALID); end
      tick();
      IN_VALID = 1'b0;
      #1;
      n_cmp++; if (BRANCH_OUT !== 1'b0) begin n_err++; $display("FAIL br_pulse got %h want 0", BRANCH_OUT); end
      n_cmp++; if (CC !== 3'b100) begin n_err++; $display("FAIL br_cc got %b want 100", CC); end
      n_cmp++; if (RESULT !== 16'h0120 || OP_to_MEM !== 3'b000) begin
         n_err++; $display("FAIL br_result got %h/%b want 0120/000", RESULT, OP_to_MEM); end
      BRANCH_IN = 1'b0;
   endtask

   task automatic test_alu_ops();
      logic [2:0]  ops [3] = '{3'b010, 3'b100, 3'b101};
      logic [15:0] a   [3] = '{16'h1000, 16'hF0F0, 16'hFFFF};
      logic [15:0] b   [3] = '{16'hBEEF, 16'h0FF0, 16'h0001};
      logic [15:0] exp_r [3] = '{16'h1010, 16'h00F0, 16'hFFFE};
      logic [2:0]  exp_cc[3] = '{3'b100, 3'b001, 3'b100};
      MEM_OFFSET = 16'h0008;
      for (int i = 0; i < 3; i++) begin
         drive(ops[i], a[i], b[i], 3'(i + 5));
         tick();
         n_cmp++; if (RESULT !== exp_r[i] || CC !== exp_cc[i] || MEMDATA !== b[i]) begin
            n_err++; $display("FAIL alu_op%0d got %h/%b/%h want %h/%b/%h", i, RESULT, CC, MEMDATA,
                              exp_r[i], exp_cc[i], b[i]); end
      end
      IN_VALID = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      drive(3'b001, 16'h0002, 16'h0003, 3'd1);
      tick();
      OUT_READY = 1'b0;
      drive(3'b101, 16'h00FF, 16'h0F0F, 3'd6);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d got %h want 0", i, IN_READY); end
         tick();
         n_cmp++; if (RESULT !== 16'h0005 || OUT_VALID !== 1'b1 || DR_to_MEM !== 3'd1) begin
            n_err++; $display("FAIL bp_hold%0d got %h/%h/%h want 0005/1/1", i, RESULT, OUT_VALID, DR_to_MEM); end
      end
      OUT_READY = 1'b1;
      #1;
      n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL bp_release got %h want 1", IN_READY); end
      tick();
      IN_VALID = 1'b0;
      n_cmp++; if (RESULT !== 16'h0FF0 || OUT_VALID !== 1'b1 || CC !== 3'b001) begin
         n_err++; $display("FAIL bp_next got %h/%h/%b want 0FF0/1/001", RESULT, OUT_VALID, CC); end
      tick();
      n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL bp_drain got %h want 0", OUT_VALID); end
   endtask

`ifdef EX_MUL_EN
   task automatic test_mul();
      int edges;
      drive(3'b111, 16'h0003, 16'h0005, 3'd7);
      #1;
      n_cmp++; if (IN_READY !== 1'b1 || FWD_VALID !== 1'b0) begin
         n_err++; $display("FAIL mul_accept got rdy=%h fwd=%h want 1/0", IN_READY, FWD_VALID); end
      tick();
      IN_VALID = 1'b0;
      edges = 0;
      while (OUT_VALID !== 1'b1 && edges < 10) begin
         n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL mul_busy_ready got %h want 0", IN_READY); end
         tick();
         edges++;
      end
      n_cmp++; if (edges !== 4) begin n_err++; $display("FAIL mul_latency got %0d want 4", edges); end
      n_cmp++; if (RESULT !== 16'h000F || CC !== 3'b001 || MEMDATA !== 16'h0005 || DR_to_MEM !== 3'd7) begin
         n_err++; $display("FAIL mul_result got %h/%b/%h/%h want 000F/001/0005/7", RESULT, CC, MEMDATA, DR_to_MEM); end
      tick();
      // Abort a multiply with reset two cycles after accept
      drive(3'b111, 16'h0003, 16'h0005, 3'd2);
      tick();
      IN_VALID = 1'b0;
      tick();
      tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL mul_abort%0d got %h want 0", i, OUT_VALID); end
         tick();
      end
      n_cmp++; if (RESULT !== 16'h0 || CC !== 3'b0 || MEMDATA !== 16'h0 || OP_to_MEM !== 3'b0 || IN_READY !== 1'b1) begin
         n_err++; $display("FAIL mul_abort_regs got %h/%b/%h/%b/%h want 0/0/0/0/1", RESULT, CC, MEMDATA, OP_to_MEM, IN_READY); end
   endtask
`else
   task automatic test_mul();
      drive(3'b111, 16'h0003, 16'h0005, 3'd7);
      #1;
      n_cmp++; if (FWD_VALID !== 1'b0 || IN_READY !== 1'b1) begin
         n_err++; $display("FAIL nomul_accept got fwd=%h rdy=%h want 0/1", FWD_VALID, IN_READY); end
      tick();
      IN_VALID = 1'b0;
      n_cmp++; if (RESULT !== 16'h0000 || CC !== 3'b010 || OUT_VALID !== 1'b1 || OP_to_MEM !== 3'b111) begin
         n_err++; $display("FAIL nomul_result got %h/%b/%h/%b want 0000/010/1/111", RESULT, CC, OUT_VALID, OP_to_MEM); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_branch();
      test_alu_ops();
      test_backpressure();
      test_mul();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
Parametrised execute stage, successor to the fixed 16-bit EX stage. Sits between decode/issue and MEM.
- Wider ALU op set, including an optional multi-cycle multiply.
- Valid/ready handshake on both sides, so MEM back-pressure and multi-cycle ops stall issue instead of dropping instructions.
- Provides branch-target and result-forwarding outputs.

Parameters:
- DATA_W, 16, datapath width (>=8).
- REG_AW, 3, destination-register index width.
- MUL_CYCLES, 4, multiply latency in cycles from accept to OUT_VALID (>=2; used only with EX_MUL_EN).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- IN_VALID  in  1  issue has an instruction.
- IN_READY  out  1  stage can accept this cycle.
- ALUOP  in  3  000 BR, 001 ADD, 010 MEM addr (LDW/STW), 011 SUB, 100 AND, 101 XOR, 110 SHL, 111 MUL.
- OPERAND1, OPERAND2  in  DATA_W  source operands.
- PC, PC_OFFSET, MEM_OFFSET  in  DATA_W  branch/mem inputs.
- DR  in  REG_AW  destination register.
- BRANCH_IN  in  1  branch taken (from decode).
- OUT_VALID  out  1  MEM-side register holds a result.
- OUT_READY  in  1  MEM accepts.
- RESULT, MEMDATA  out  DATA_W  registered result / store data.
- OP_to_MEM  out  3  registered op.
- DR_to_MEM  out  REG_AW  registered destination.
- CC  out  3  registered condition code {N,Z,P}.
- BRANCH_OUT  out  1  branch redirect strobe.
- BRANCH_ADDR  out  DATA_W  branch target.
- EX_result_forward  out  DATA_W  combinational single-cycle ALU result.
- FWD_VALID  out  1  forward value valid this cycle.
- DR_EX_RETURN  out  REG_AW  DR of the instruction in EX.

Behaviour:
- accept = IN_VALID & IN_READY.
- IN_READY = (state==IDLE) & (!OUT_VALID | OUT_READY).
- Arithmetic is modulo 2^DATA_W:
  - BR: PC + (PC_OFFSET<<1).
  - ADD: OP1+OP2.
  - MEM: OP1 + (MEM_OFFSET<<1).
  - SUB: OP1-OP2.
  - AND / XOR: bitwise.
  - SHL: OP1 << OP2[$clog2(DATA_W)-1:0].
  - MUL: low DATA_W bits of OP1*OP2.
- States: IDLE, MUL_BUSY.
- Single-cycle op accepted at edge N: RESULT, OP_to_MEM, DR_to_MEM, MEMDATA(=OPERAND2) and OUT_VALID=1 are visible after edge N.
- MUL accepted: go to MUL_BUSY and load a counter with MUL_CYCLES-1.
  - IN_READY=0 while in MUL_BUSY.
  - When the counter reaches 0, register the outputs, set OUT_VALID=1 and return to IDLE.
  - Total latency is MUL_CYCLES edges.
- Back-pressure: while OUT_VALID & !OUT_READY, all output registers hold stable and IN_READY=0.
  - A MUL in MUL_BUSY may finish its count but waits in MUL_BUSY with the counter at 0 until the output register frees.
- OUT_VALID clears on OUT_READY with no new completion in the same cycle. Completion plus OUT_READY in the same cycle: registers reload and OUT_VALID stays 1.
- CC updates with the registered result for ADD/SUB/AND/XOR/SHL/MUL only. BR/MEM leave CC unchanged.
  - Result 0 gives 010; MSB set gives 100; otherwise 001.
- BRANCH_ADDR is always the combinational BR sum. BRANCH_OUT = accept & BRANCH_IN & (ALUOP==000), asserted for one cycle.
- FWD_VALID = accept & single-cycle op & ALUOP not in {BR, MEM}. EX_result_forward = combinational result. DR_EX_RETURN = DR.
- RESET (synchronous): state IDLE, counter 0, OUT_VALID 0, and RESULT, MEMDATA, OP_to_MEM, DR_to_MEM, CC all 0.
  - Reset during MUL_BUSY aborts the multiply; no result is ever emitted.
  - RESET has priority over accept in the same cycle.

Optional Feature:
EX_MUL_EN
- Defined: MUL is implemented as above (multi-cycle, MUL_CYCLES latency).
- Undefined: no multiplier, counter or MUL_BUSY state.
  - Opcode 111 completes as a single-cycle op with RESULT=0 and CC=010.
  - FWD_VALID=0 for opcode 111.

Test Plan:
- DATA_W=16, ADD 0x7FFF+0x0001, OUT_READY=1 -> next cycle RESULT=0x8000, CC=100, OUT_VALID=1; FWD_VALID=1 in the accept cycle with forward value 0x8000.
- SUB 5-5 then SHL 0x0001<<15 back-to-back -> RESULTs 0x0000 (CC=010) then 0x8000 (CC=100), one per cycle, IN_READY held 1.
- BR with PC=0x0100, PC_OFFSET=0x0010, BRANCH_IN=1 -> BRANCH_ADDR=0x0120, BRANCH_OUT pulse one cycle, CC unchanged.
- OUT_READY=0 for 3 cycles after an ADD -> outputs frozen, IN_READY=0, pending IN_VALID op accepted in the cycle OUT_READY returns.
- EX_MUL_EN, MUL_CYCLES=4, 0x0003*0x0005 -> OUT_VALID with RESULT=0x000F exactly 4 edges after accept, IN_READY=0 in between; repeat with RESET asserted 2 cycles in -> no result emitted, all outputs 0.
- Without EX_MUL_EN, opcode 111 -> RESULT=0, CC=010 after 1 cycle, FWD_VALID=0.
